serial_arith: RTL and testbench

- Bit-serial arithmetic/logic unit built around a single 1-bit ADD/SUB/AND/OR slice, the same operation set as our gate-level combinational slice.
- The slice is time-multiplexed across a W-bit word. A carry/borrow flip-flop carries the chain from one bit to the next.
- Accepts parallel operands with a start handshake and returns a parallel result with a one-cycle done pulse.
- Used where area matters more than latency.

---
 rtl/serial_arith.sv | 128 ++++++++++++
 tb/tb_serial_arith.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_arith.sv
// Bit-serial ADD/SUB/AND/OR unit: one 1-bit slice reused across a W-bit word,
// with a carry/borrow flop linking successive bits. Start/ready in, done pulse out.
module serial_arith #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y,
  output logic         cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  y_q, y_d;
  logic          cout_q, cout_d;

  logic slice_bit, slice_carry;

  // The single shared 1-bit slice.
  always_comb begin
    slice_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    slice_carry = 1'b0;
    case (op_q)
      OP_ADD: slice_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q)
                          | (b_sh_q[0] & carry_q);
      OP_SUB: slice_carry = (~a_sh_q[0] & b_sh_q[0]) | (~a_sh_q[0] & carry_q)
                          | (b_sh_q[0] & carry_q);
      OP_AND: slice_bit   = a_sh_q[0] & b_sh_q[0];
      default: slice_bit  = a_sh_q[0] | b_sh_q[0];
    endcase
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    op_d    = op_q;
    res_d   = res_q;
    y_d     = y_q;
    cout_d  = cout_q;

    case (state_q)
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {slice_bit, res_q[W-1:1]};
        carry_d = slice_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
          y_d     = {slice_bit, res_q[W-1:1]};
          cout_d  = slice_carry;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = op[1] ? 1'b0 : cin;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      op_q    <= op_d;
      res_q   <= res_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q != S_RUN);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign y     = y_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_arith.sv
// Self-checking bench for serial_arith: directed cases with literal results plus
// randomized traffic compared each cycle against a word-level timing model.
module tb_serial_arith;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, done, cout;
  logic [W-1:0] y;

  serial_arith #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .y(y), .cout(cout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level result: {carry/borrow, y}.
  function automatic logic [W:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                       input logic [W-1:0] z, input logic ci);
    case (o)
      2'b00:   return {1'b0, x} + {1'b0, z} + {{W{1'b0}}, ci};
      2'b01:   return {1'b0, x} - {1'b0, z} - {{W{1'b0}}, ci};
      2'b10:   return {1'b0, x & z};
      default: return {1'b0, x | z};
    endcase
  endfunction

  // Timing model: an accepted request completes W edges later; y/cout update then.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_cout = 1'b0;
  logic [W-1:0] m_y = '0;
  logic [W:0]   m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_cout = 1'b0;
      m_y    = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_cout, m_y} = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pend = ref_op(op, a, b, cin);
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n)
      check("cycle {ready,busy,done,cout,y}", {ready, busy, done, cout, y},
            {(m_left == 0), (m_left > 0), m_done, m_cout, m_y});
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] z, input logic ci,
                        input logic [W-1:0] exp_y, input logic exp_c);
    int n;
    int nb;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = z; cin = ci;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    nb = 0;
    while (!done && n < 30) begin
      if (busy) nb++;
      n++;
      @(negedge clk);
    end
    check({name, " done seen"}, done, 1'b1);
    check({name, " latency"}, n, W);
    check({name, " busy cycles"}, nb, W);
    check({name, " y"}, y, exp_y);
    check({name, " cout"}, cout, exp_c);
  endtask

  initial begin
    int n;
    int ndone;
    logic [W-1:0] yc;
    logic cc;

    // Pin the reference model on hand-computed values.
    check("model add", ref_op(2'b00, 8'hFF, 8'h01, 1'b0), 9'h100);
    check("model sub", ref_op(2'b01, 8'h05, 8'h07, 1'b0), 9'h1FE);
    check("model sub borrow-in", ref_op(2'b01, 8'h07, 8'h05, 1'b1), 9'h001);

    repeat (2) @(negedge clk);
    check("reset outputs", {ready, busy, done, cout, y}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op("add ff+01", 2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("sub 05-07", 2'b01, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1);
    run_op("sub 07-05-1", 2'b01, 8'h07, 8'h05, 1'b1, 8'h01, 1'b0);
    run_op("and", 2'b10, 8'hA5, 8'h3C, 1'b1, 8'h24, 1'b0);
    run_op("or", 2'b11, 8'hA5, 8'h3C, 1'b1, 8'hBD, 1'b0);

    // start during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'h10; b = 8'h20; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; yc = '0; cc = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) begin ndone++; yc = y; cc = cout; end
    end
    check("ignored start done count", ndone, 1);
    check("ignored start y", yc, 8'h30);
    check("ignored start cout", cc, 1'b0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", {ready, busy, done, cout, y},
             {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no done after abort", ndone, 0);
    run_op("add after reset", 2'b00, 8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

    // Back-to-back with start held through DONE.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'h01; b = 8'h02; cin = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 30) begin n++; @(negedge clk); end
    check("b2b first done", done, 1'b1);
    check("b2b first y", y, 8'h03);
    a = 8'h80; b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 30) begin n++; @(negedge clk); end
    check("b2b done spacing", n, W + 1);
    check("b2b second y", y, 8'h00);
    check("b2b second cout", cout, 1'b1);

    // Randomized traffic, including starts during RUN and mid-run input changes.
    repeat (800) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
